// File: rtl/finger_count_accumulator_if.sv
// Gesture event handshake between the accumulator and its consumer.
interface finger_count_accumulator_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;

  modport master (output out_valid, output out_value, input out_ready);
  modport slave  (input out_valid, input out_value, output out_ready);
endinterface

// File: rtl/finger_count_accumulator.sv
// Debounces a 5-bit hand shape, decodes each committed gesture, emits it as
// one handshake event and adds accepted values into a saturating sum.
//
// state | meaning
// IDLE  | waiting for a stable shape to commit
// EMIT  | event pending on out_if, value frozen until accepted
// HOLD  | committed shape still present; wait for it to change
module finger_count_accumulator #(
  parameter int STABLE_CYCLES = 4,
  parameter int SUM_W         = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [4:0]                   hs,
  input  logic                         mode,
  input  logic                         clear,
  finger_count_accumulator_if.master   out_if,
  output logic [SUM_W-1:0]             sum,
  output logic                         sat,
  output logic                         err_invalid
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [4:0]       cand;
  logic [4:0]       last;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [3:0]       out_value_q;
  logic             dec_valid;
  logic [3:0]       dec_value;
  logic             stable;
  logic             accept;
  logic [SUM_W:0]   sum_add;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_value = out_value_q;

  assign stable  = (cnt == CNT_MAX);
  assign accept  = out_valid_q && out_if.out_ready;
  // Carry out of the widened adder means the running sum overflowed.
  assign sum_add = {1'b0, sum} + {{(SUM_W-3){1'b0}}, out_value_q};

  // Decode the debounced candidate shape in the currently selected mode.
  always_comb begin
    dec_valid = 1'b0;
    dec_value = 4'd0;
    if (mode) begin
      dec_valid = 1'b1;
      dec_value = 4'(cand[0]) + 4'(cand[1]) + 4'(cand[2]) + 4'(cand[3]) + 4'(cand[4]);
    end else begin
      case (cand)
        5'b00001: begin dec_valid = 1'b1; dec_value = 4'd1;  end
        5'b00011: begin dec_valid = 1'b1; dec_value = 4'd2;  end
        5'b00111: begin dec_valid = 1'b1; dec_value = 4'd3;  end
        5'b01111: begin dec_valid = 1'b1; dec_value = 4'd4;  end
        5'b11111: begin dec_valid = 1'b1; dec_value = 4'd5;  end
        5'b11110: begin dec_valid = 1'b1; dec_value = 4'd6;  end
        5'b11100: begin dec_valid = 1'b1; dec_value = 4'd7;  end
        5'b11000: begin dec_valid = 1'b1; dec_value = 4'd8;  end
        5'b10000: begin dec_valid = 1'b1; dec_value = 4'd9;  end
        5'b00000: begin dec_valid = 1'b1; dec_value = 4'd10; end
        default:  begin dec_valid = 1'b0; dec_value = 4'd0;  end
      endcase
    end
  end

  // Debouncer: count consecutive identical samples, saturating at the threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= 5'd0;
      cnt  <= '0;
    end else if (hs == cand) begin
      if (!stable) cnt <= cnt + 1'b1;
    end else begin
      cand <= hs;
      cnt  <= CNT_W'(1);
    end
  end

  // Gesture FSM: commit once, emit one event, then wait for the shape to change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last        <= 5'd0;
      out_valid_q <= 1'b0;
      out_value_q <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (stable) begin
            last <= cand;
            if (dec_valid) begin
              out_value_q <= dec_value;
              out_valid_q <= 1'b1;
              state       <= EMIT;
            end else begin
              state <= HOLD;
            end
          end
        end
        EMIT: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (cand != last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Running sum and sticky flags; clear wins over a same-cycle accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum         <= '0;
      sat         <= 1'b0;
      err_invalid <= 1'b0;
    end else if (clear) begin
      sum         <= '0;
      sat         <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      if (state == EMIT && accept) begin
        if (sum_add[SUM_W]) begin
          sum <= '1;
          sat <= 1'b1;
        end else begin
          sum <= sum_add[SUM_W-1:0];
        end
      end
      if (state == IDLE && stable && !dec_valid) err_invalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_finger_count_accumulator.sv
// Bench for finger_count_accumulator: gesture table, hand-written corner
// sequences and random stimulus, all compared against a reference model.
module tb_finger_count_accumulator;
  localparam int ST = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] hs_v = 5'd0;
  logic       mode_v = 1'b0;
  logic       clear_v = 1'b0;
  logic       ready_v = 1'b1;

  logic [7:0] sum8;
  logic       sat8, err8;
  logic [3:0] sum4;
  logic       sat4, err4;

  finger_count_accumulator_if if8 ();
  finger_count_accumulator_if if4 ();
  assign if8.out_ready = ready_v;
  assign if4.out_ready = ready_v;

  finger_count_accumulator #(.STABLE_CYCLES(ST), .SUM_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .hs(hs_v), .mode(mode_v), .clear(clear_v),
    .out_if(if8), .sum(sum8), .sat(sat8), .err_invalid(err8));

  finger_count_accumulator #(.STABLE_CYCLES(ST), .SUM_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .hs(hs_v), .mode(mode_v), .clear(clear_v),
    .out_if(if4), .sum(sum4), .sat(sat4), .err_invalid(err4));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: sample history, a pending-event flag and a
  // "gesture consumed, waiting for release" flag.
  logic [4:0] hq[$];
  bit         m_pending, m_hold, m_sat8, m_sat4, m_err;
  logic [4:0] m_last;
  int         m_val, m_sum8, m_sum4;

  function automatic void decode(input logic [4:0] s, input bit md, output bit ok, output int v);
    ok = 0; v = 0;
    if (md) begin
      ok = 1; v = $countones(s);
    end else begin
      for (int n = 1; n <= 5; n++) begin
        if (s == 5'((1 << n) - 1))        begin ok = 1; v = n;     end
        if (s == 5'(31 ^ ((1 << n) - 1))) begin ok = 1; v = 5 + n; end
      end
    end
  endfunction

  function automatic int run_len();
    int r = 0;
    if (hq.size() == 0) return 0;
    for (int i = hq.size() - 1; i >= 0; i--) begin
      if (hq[i] == hq[hq.size()-1]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic model_reset();
    hq.delete();
    m_pending = 0; m_hold = 0; m_last = 5'd0; m_val = 0;
    m_sum8 = 0; m_sum4 = 0; m_sat8 = 0; m_sat4 = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [4:0] cand;
    bit ok;
    int v;
    cand = (hq.size() == 0) ? 5'd0 : hq[hq.size()-1];
    if (m_pending) begin
      if (ready_v) begin
        m_pending = 0;
        m_hold = 1;
        if (m_sum8 + m_val > 255) begin m_sum8 = 255; m_sat8 = 1; end
        else m_sum8 = m_sum8 + m_val;
        if (m_sum4 + m_val > 15) begin m_sum4 = 15; m_sat4 = 1; end
        else m_sum4 = m_sum4 + m_val;
      end
    end else if (m_hold) begin
      if (cand != m_last) m_hold = 0;
    end else if (run_len() >= ST) begin
      m_last = cand;
      decode(cand, mode_v, ok, v);
      if (ok) begin m_pending = 1; m_val = v; end
      else begin m_hold = 1; m_err = 1; end
    end
    if (clear_v) begin
      m_sum8 = 0; m_sum4 = 0; m_sat8 = 0; m_sat4 = 0; m_err = 0;
    end
    hq.push_back(hs_v);
    if (hq.size() > ST) void'(hq.pop_front());
  endtask

  task automatic cmp_all();
    chk($sformatf("c%0d valid8", cyc), if8.out_valid, m_pending);
    chk($sformatf("c%0d value8", cyc), if8.out_value, m_val);
    chk($sformatf("c%0d sum8", cyc), sum8, m_sum8);
    chk($sformatf("c%0d sat8", cyc), sat8, m_sat8);
    chk($sformatf("c%0d err8", cyc), err8, m_err);
    chk($sformatf("c%0d valid4", cyc), if4.out_valid, m_pending);
    chk($sformatf("c%0d sum4", cyc), sum4, m_sum4);
    chk($sformatf("c%0d sat4", cyc), sat4, m_sat4);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    cmp_all();
  endtask

  task automatic run_hold(input logic [4:0] s, input bit md, input int n, output int ev, output int val);
    hs_v = s; mode_v = md; ready_v = 1'b1;
    ev = 0; val = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (if8.out_valid) begin ev++; val = if8.out_value; end
    end
  endtask

  typedef struct {
    logic [4:0] hs;
    bit         mode;
    int         hold;
    int         exp_ev;
    int         exp_val;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int ev, val, s0, found;
    logic [4:0] shapes[12];

    tbl[0]  = '{5'b00111, 1'b0, 8, 1, 3};
    tbl[1]  = '{5'b00000, 1'b0, 6, 1, 10};
    tbl[2]  = '{5'b10000, 1'b0, 6, 1, 9};
    tbl[3]  = '{5'b11000, 1'b0, 6, 1, 8};
    tbl[4]  = '{5'b11111, 1'b1, 6, 1, 5};
    tbl[5]  = '{5'b01010, 1'b1, 6, 1, 2};
    tbl[6]  = '{5'b01111, 1'b0, 6, 1, 4};
    tbl[7]  = '{5'b00001, 1'b0, 6, 1, 1};
    tbl[8]  = '{5'b11110, 1'b0, 6, 1, 6};
    tbl[9]  = '{5'b11100, 1'b0, 6, 1, 7};
    tbl[10] = '{5'b10101, 1'b0, 6, 0, 0};
    tbl[11] = '{5'b00000, 1'b1, 2, 0, 0};
    tbl[12] = '{5'b10101, 1'b1, 6, 1, 3};

    shapes = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11110,
               5'b11100, 5'b11000, 5'b10000, 5'b00000, 5'b10101, 5'b01010};

    model_reset();
    hs_v = 5'b00111;
    #2;
    chk("reset valid", if8.out_valid, 0);
    chk("reset value", if8.out_value, 0);
    chk("reset sum", sum8, 0);
    chk("reset sat", sat8, 0);
    chk("reset err", err8, 0);
    #10;
    reset_n = 1'b1;

    // Table of gestures, each checked for event count and value.
    for (int i = 0; i < 13; i++) begin
      if (i == 1) s0 = m_sum8;
      run_hold(tbl[i].hs, tbl[i].mode, tbl[i].hold, ev, val);
      chk($sformatf("tbl%0d events", i), ev, tbl[i].exp_ev);
      if (tbl[i].exp_ev != 0) chk($sformatf("tbl%0d value", i), val, tbl[i].exp_val);
      if (i == 3) chk("seq 10+9+8", sum8 - s0, 27);
      if (i == 10) chk("invalid err", err8, 1);
    end

    // Backpressure: event 5 held while the shape moves on.
    mode_v = 1'b0; hs_v = 5'b11111; ready_v = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp valid", if8.out_valid, 1);
    chk("bp value", if8.out_value, 5);
    hs_v = 5'b00011;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("bp hold%0d valid", i), if8.out_valid, 1);
      chk($sformatf("bp hold%0d value", i), if8.out_value, 5);
    end
    s0 = m_sum8;
    ready_v = 1'b1;
    step();
    chk("bp accept sum", sum8, (s0 + 5 > 255) ? 255 : s0 + 5);
    found = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (found == 0 && if8.out_valid) found = if8.out_value;
    end
    chk("bp next event", found, 2);

    // Saturation on the narrow accumulator, then clear racing a handshake.
    clear_v = 1'b1; step(); clear_v = 1'b0;
    run_hold(5'b00000, 1'b0, 6, ev, val);
    run_hold(5'b10000, 1'b0, 6, ev, val);
    chk("sat4 sum", sum4, 15);
    chk("sat4 flag", sat4, 1);
    chk("sat8 sum", sum8, 19);
    hs_v = 5'b11000;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step();
      if (if8.out_valid) found = 1;
    end
    chk("clr race saw event", found, 1);
    clear_v = 1'b1; step(); clear_v = 1'b0;
    chk("clr race sum4", sum4, 0);
    chk("clr race sat4", sat4, 0);
    chk("clr race sum8", sum8, 0);
    chk("clr race valid", if8.out_valid, 0);

    // Glitching shape never commits.
    for (int i = 0; i < 8; i++) begin
      hs_v = i[0] ? 5'b00011 : 5'b00001;
      step();
      chk($sformatf("glitch%0d valid", i), if8.out_valid, 0);
    end

    // Reset in the middle of a pending event.
    hs_v = 5'b00001; ready_v = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre-reset valid", if8.out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset valid", if8.out_valid, 0);
    chk("midreset value", if8.out_value, 0);
    chk("midreset sum8", sum8, 0);
    chk("midreset sum4", sum4, 0);
    chk("midreset err", err8, 0);
    model_reset();
    #2 reset_n = 1'b1;

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(4, 0) == 0) begin
        if ($urandom_range(3, 0) == 0) hs_v = 5'($urandom);
        else hs_v = shapes[$urandom_range(11, 0)];
      end
      if ($urandom_range(9, 0) == 0) mode_v = ~mode_v;
      ready_v = ($urandom_range(9, 0) < 7);
      clear_v = ($urandom_range(39, 0) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
